// File: rtl/spi_master_fifo.sv
// SFR-mapped SPI master with TX/RX FIFOs, burst transfers, all four CPOL/CPHA
// modes, MSB/LSB-first shifting and sticky overflow flags.
module spi_master_fifo #(
  parameter int DW    = 8,
  parameter int NSS   = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sfrwe,
  input  logic [2:0]     sfraddr_w,
  input  logic [DW-1:0]  sfrdata_i,
  input  logic           sfrre,
  input  logic [2:0]     sfraddr_r,
  output logic [DW-1:0]  sfrdata_o,
  input  logic           miso,
  output logic           sck,
  output logic           mosi,
  output logic [NSS-1:0] ss_n,
  output logic           irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = $clog2(2 * DW);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;
  state_t state_reg, state_next;

  logic [5:0]     cr_reg;
  logic [NSS-1:0] ssel_reg, ss_reg;
  logic [7:0]     br_reg, br_l_reg, div_cnt_reg;
  logic           txovf_reg, rxovf_reg;
  logic           cpol_l_reg, cpha_l_reg, lsbf_l_reg;
  logic           sck_reg, mosi_reg;
  logic [EW-1:0]  edge_cnt_reg;
  logic [DW-1:0]  tx_shift_reg, rx_shift_reg, rx_sampled, rx_word;

  logic [1:0]         f_push, f_pop, f_empty, f_full, f_drop;
  logic [1:0][DW-1:0] f_wdata, f_rdata;

  logic wr_cr, wr_ssel, wr_br, wr_tx, wr_sr, rd_rx, en_clear, abort, start;
  logic half_done, last_edge, sample_edge, tx_pop, rx_push, busy, ld_cpha, ld_lsbf;
  logic tx_empty, rx_empty;
  logic [6:0] sr;

  function automatic logic head_bit(input logic [DW-1:0] w, input logic lsbf);
    return lsbf ? w[0] : w[DW-1];
  endfunction

  function automatic logic [DW-1:0] drop_bit(input logic [DW-1:0] w, input logic lsbf);
    return lsbf ? {1'b0, w[DW-1:1]} : {w[DW-2:0], 1'b0};
  endfunction

  assign wr_cr    = sfrwe && (sfraddr_w == 3'd0);
  assign wr_ssel  = sfrwe && (sfraddr_w == 3'd1);
  assign wr_br    = sfrwe && (sfraddr_w == 3'd2);
  assign wr_tx    = sfrwe && (sfraddr_w == 3'd3);
  assign wr_sr    = sfrwe && (sfraddr_w == 3'd5);
  assign rd_rx    = sfrre && (sfraddr_r == 3'd4);
  assign en_clear = wr_cr && !sfrdata_i[0];
  assign abort    = en_clear && (state_reg != IDLE);

  assign tx_empty = f_empty[0];
  assign rx_empty = f_empty[1];
  assign f_push   = {rx_push, wr_tx};
  assign f_pop    = {rd_rx, tx_pop};
  assign f_wdata  = {rx_word, sfrdata_i};

  // Index 0 is the TX FIFO, index 1 the RX FIFO; head is readable combinationally.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DW-1:0] mem [DEPTH];
      logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
      logic [AW:0]   count_reg;
      logic          do_push, do_pop;

      assign do_pop      = f_pop[gi] && (count_reg != '0);
      assign do_push     = f_push[gi] && ((count_reg != (AW+1)'(DEPTH)) || do_pop);
      assign f_drop[gi]  = f_push[gi] && !do_push;
      assign f_empty[gi] = (count_reg == '0);
      assign f_full[gi]  = (count_reg == (AW+1)'(DEPTH));
      assign f_rdata[gi] = mem[rd_ptr_reg];

      always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= f_wdata[gi];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
          if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
          count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
      end
    end
  endgenerate

  assign busy        = (state_reg != IDLE);
  assign start       = (state_reg == IDLE) && cr_reg[0] && !tx_empty && !en_clear;
  assign half_done   = busy && (div_cnt_reg == br_l_reg);
  assign last_edge   = (state_reg == SHIFT) && half_done && (edge_cnt_reg == LAST_EDGE);
  // Edge number is edge_cnt+1, so an even count is an odd (leading) edge.
  assign sample_edge = (edge_cnt_reg[0] == cpha_l_reg);
  assign rx_sampled  = lsbf_l_reg ? {miso, rx_shift_reg[DW-1:1]} : {rx_shift_reg[DW-2:0], miso};
  assign rx_word     = sample_edge ? rx_sampled : rx_shift_reg;
  assign ld_cpha     = (state_reg == IDLE) ? cr_reg[2] : cpha_l_reg;
  assign ld_lsbf     = (state_reg == IDLE) ? cr_reg[3] : lsbf_l_reg;

  always_comb begin
    state_next = state_reg;
    tx_pop     = 1'b0;
    rx_push    = 1'b0;
    case (state_reg)
      IDLE:  if (start) begin state_next = SETUP; tx_pop = 1'b1; end
      SETUP: if (half_done) state_next = SHIFT;
      SHIFT: if (last_edge) begin
        rx_push = 1'b1;
        if (!tx_empty) tx_pop = 1'b1;
        else           state_next = HOLD;
      end
      HOLD:  if (half_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) begin
      state_next = IDLE;
      tx_pop     = 1'b0;
      rx_push    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cr_reg <= '0; ssel_reg <= '0; br_reg <= '0;
      txovf_reg <= 1'b0; rxovf_reg <= 1'b0;
    end else begin
      if (wr_cr)   cr_reg   <= sfrdata_i[5:0];
      if (wr_ssel) ssel_reg <= sfrdata_i[NSS-1:0];
      if (wr_br)   br_reg   <= sfrdata_i[7:0];
      if (f_drop[0])                      txovf_reg <= 1'b1;
      else if (wr_sr && sfrdata_i[5])     txovf_reg <= 1'b0;
      if (f_drop[1])                      rxovf_reg <= 1'b1;
      else if (wr_sr && sfrdata_i[6])     rxovf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_reg <= '1; sck_reg <= 1'b0; mosi_reg <= 1'b0;
      div_cnt_reg <= '0; edge_cnt_reg <= '0; br_l_reg <= '0;
      cpol_l_reg <= 1'b0; cpha_l_reg <= 1'b0; lsbf_l_reg <= 1'b0;
      tx_shift_reg <= '0; rx_shift_reg <= '0;
    end else if (busy && state_next == IDLE) begin
      // End of HOLD or abort: release the slave and park the clock.
      ss_reg      <= '1;
      sck_reg     <= cr_reg[1];
      div_cnt_reg <= '0;
    end else if (!busy) begin
      sck_reg <= cr_reg[1];
      if (tx_pop) begin
        cpol_l_reg   <= cr_reg[1];
        cpha_l_reg   <= cr_reg[2];
        lsbf_l_reg   <= cr_reg[3];
        br_l_reg     <= br_reg;
        ss_reg       <= ~ssel_reg;
        div_cnt_reg  <= '0;
        edge_cnt_reg <= '0;
      end
    end else begin
      div_cnt_reg <= half_done ? 8'd0 : div_cnt_reg + 8'd1;
      if (state_reg == SHIFT && half_done) begin
        sck_reg      <= ~sck_reg;
        edge_cnt_reg <= last_edge ? '0 : edge_cnt_reg + EW'(1);
        if (sample_edge) rx_shift_reg <= rx_sampled;
        if (!sample_edge && !tx_pop) begin
          mosi_reg     <= head_bit(tx_shift_reg, lsbf_l_reg);
          tx_shift_reg <= drop_bit(tx_shift_reg, lsbf_l_reg);
        end
      end
    end
    // Word load for frame start and burst continuation; CPHA=0 drives bit 0 immediately.
    if (!rst && tx_pop) begin
      if (!ld_cpha) begin
        mosi_reg     <= head_bit(f_rdata[0], ld_lsbf);
        tx_shift_reg <= drop_bit(f_rdata[0], ld_lsbf);
      end else begin
        tx_shift_reg <= f_rdata[0];
      end
    end
  end

  assign sr = {rxovf_reg, txovf_reg, f_full[1], rx_empty, f_full[0], tx_empty, busy};

  always_comb begin
    sfrdata_o = '0;
    case (sfraddr_r)
      3'd0: sfrdata_o[5:0]     = cr_reg;
      3'd1: sfrdata_o[NSS-1:0] = ssel_reg;
      3'd2: sfrdata_o[7:0]     = br_reg;
      3'd4: if (!rx_empty) sfrdata_o = f_rdata[1];
      3'd5: sfrdata_o[6:0]     = sr;
      default: sfrdata_o = '0;
    endcase
  end

  assign sck  = sck_reg;
  assign mosi = mosi_reg;
  assign ss_n = ss_reg;
  assign irq  = (cr_reg[4] & ~rx_empty) | (cr_reg[5] & tx_empty & ~busy);

endmodule

// File: tb/tb_spi_master_fifo.sv
// Directed bench for spi_master_fifo: register map, loopback frame, four modes
// against a model slave, burst/overflow, abort and mid-frame reset.
module tb_spi_master_fifo;
  localparam int DW = 8, NSS = 8, DEPTH = 4;

  logic           clk = 1'b0;
  logic           rst, sfrwe, sfrre, miso, sck, mosi, irq;
  logic [2:0]     sfraddr_w, sfraddr_r;
  logic [DW-1:0]  sfrdata_i, sfrdata_o;
  logic [NSS-1:0] ss_n;

  int   total = 0;
  int   bad   = 0;
  logic loopback;
  logic slave_cpha, slave_lsbf, slave_bit, slave_prev;
  logic [7:0] slave_word;
  int   slave_e;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : slave_bit;

  spi_master_fifo #(.DW(DW), .NSS(NSS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sfrwe(sfrwe), .sfraddr_w(sfraddr_w), .sfrdata_i(sfrdata_i),
    .sfrre(sfrre), .sfraddr_r(sfraddr_r), .sfrdata_o(sfrdata_o), .miso(miso),
    .sck(sck), .mosi(mosi), .ss_n(ss_n), .irq(irq)
  );

  // Model slave: counts SCK edges while selected and presents the next bit of
  // slave_word after each of its own shift edges.
  always @(negedge clk) begin
    int idx;
    if (ss_n === '1) slave_e = 0;
    else if (sck !== slave_prev) slave_e++;
    slave_prev = sck;
    idx = slave_cpha ? ((slave_e > 0) ? (slave_e - 1) / 2 : 0) : slave_e / 2;
    if (idx > 7) slave_bit = 1'b0;
    else         slave_bit = slave_lsbf ? slave_word[idx] : slave_word[7 - idx];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sfr_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    sfrwe = 1'b1; sfraddr_w = a; sfrdata_i = d;
    @(negedge clk);
    sfrwe = 1'b0;
    $display("write addr=%0d data=0x%02h", a, d);
  endtask

  task automatic sfr_rd(input logic [2:0] a, input logic pop, output logic [7:0] d);
    @(negedge clk);
    sfraddr_r = a; sfrre = pop;
    #1 d = sfrdata_o;
    @(negedge clk);
    sfrre = 1'b0;
    $display("read  addr=%0d pop=%0d data=0x%02h", a, pop, d);
  endtask

  task automatic wait_frame(input string tag, output int lo, output logic [7:0] cap,
                            output logic [NSS-1:0] ssv);
    logic seen, prev;
    lo = 0; cap = '0; ssv = '1; seen = 1'b0; prev = sck;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ss_n !== '1) begin
        if (!seen) ssv = ss_n;
        seen = 1'b1;
        lo++;
        if (sck === 1'b1 && prev === 1'b0) cap = {cap[6:0], mosi};
      end else if (seen) begin
        break;
      end
      prev = sck;
    end
    chk({tag, "_ended"}, {31'd0, seen && (ss_n === '1)}, 32'd1);
    $display("frame %s: ss_n low %0d cycles, ss_n=0x%02h", tag, lo, ssv);
  endtask

  initial begin
    logic [7:0]     d;
    logic [NSS-1:0] ssv;
    int             lo, rises;
    logic           found;

    rst = 1'b1; sfrwe = 1'b0; sfrre = 1'b0; sfraddr_w = '0; sfraddr_r = '0; sfrdata_i = '0;
    loopback = 1'b1; slave_cpha = 1'b0; slave_lsbf = 1'b0; slave_word = 8'h3C;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ss_n", ss_n, 8'hFF);
    chk("rst_sck", sck, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_irq", irq, 1'b0);
    for (int a = 0; a < 8; a++) begin
      sfr_rd(a[2:0], 1'b0, d);
      chk($sformatf("rst_addr%0d", a), d, (a == 5) ? 8'h0A : 8'h00);
    end

    // Loopback frame, mode 0, BR=1
    sfr_wr(3'd2, 8'h01);
    sfr_wr(3'd1, 8'h04);
    sfr_wr(3'd0, 8'h01);
    sfr_wr(3'd3, 8'hA5);
    wait_frame("loop", lo, d, ssv);
    chk("loop_len", lo, 36);
    chk("loop_ss", ssv, 8'hFB);
    chk("loop_mosi", d, 8'hA5);
    sfr_rd(3'd4, 1'b1, d);
    chk("loop_rx", d, 8'hA5);
    sfr_rd(3'd5, 1'b0, d);
    chk("loop_sr", d, 8'h0A);

    // Four modes, MSB then LSB first, BR=0, model slave returns 0x3C
    sfr_wr(3'd2, 8'h00);
    loopback = 1'b0;
    for (int m = 0; m < 8; m++) begin
      logic [2:0] mb;
      mb = m[2:0];
      slave_cpha = mb[1];
      slave_lsbf = mb[2];
      sfr_wr(3'd0, {4'b0, mb, 1'b1});
      sfr_wr(3'd3, 8'h96);
      chk($sformatf("mode%0d_sck_idle", m), sck, mb[0]);
      wait_frame($sformatf("mode%0d", m), lo, d, ssv);
      chk($sformatf("mode%0d_len", m), lo, 18);
      chk($sformatf("mode%0d_sck_after", m), sck, mb[0]);
      sfr_rd(3'd4, 1'b1, d);
      chk($sformatf("mode%0d_rx", m), d, 8'h3C);
    end

    // Burst with TX overflow, then RX overflow
    loopback = 1'b1;
    sfr_wr(3'd0, 8'h00);
    sfr_wr(3'd3, 8'h11);
    sfr_wr(3'd3, 8'h22);
    sfr_wr(3'd3, 8'h33);
    sfr_wr(3'd3, 8'h44);
    sfr_rd(3'd5, 1'b0, d);
    chk("tx_full_sr", d, 8'h0C);
    sfr_wr(3'd3, 8'h55);
    sfr_rd(3'd5, 1'b0, d);
    chk("txovf_sr", d, 8'h2C);
    sfr_wr(3'd0, 8'h01);
    wait_frame("burst", lo, d, ssv);
    chk("burst_len", lo, 66);
    sfr_rd(3'd5, 1'b0, d);
    chk("burst_sr", d, 8'h32);
    sfr_wr(3'd3, 8'h66);
    wait_frame("rxfull", lo, d, ssv);
    chk("rxfull_len", lo, 18);
    sfr_rd(3'd5, 1'b0, d);
    chk("rxovf_sr", d, 8'h72);
    sfr_wr(3'd5, 8'h60);
    sfr_rd(3'd5, 1'b0, d);
    chk("w1c_sr", d, 8'h12);
    sfr_wr(3'd0, 8'h11);
    chk("irq_rx", irq, 1'b1);
    sfr_rd(3'd4, 1'b1, d);
    chk("burst_rx0", d, 8'h11);
    sfr_rd(3'd4, 1'b1, d);
    chk("burst_rx1", d, 8'h22);
    sfr_rd(3'd4, 1'b1, d);
    chk("burst_rx2", d, 8'h33);
    sfr_rd(3'd4, 1'b1, d);
    chk("burst_rx3", d, 8'h44);
    chk("irq_rx_clear", irq, 1'b0);
    sfr_rd(3'd4, 1'b1, d);
    chk("rx_empty_read", d, 8'h00);
    sfr_rd(3'd5, 1'b0, d);
    chk("drained_sr", d, 8'h0A);
    sfr_wr(3'd0, 8'h21);
    chk("irq_tx", irq, 1'b1);

    // Abort during bit 3
    sfr_wr(3'd0, 8'h00);
    sfr_wr(3'd2, 8'h03);
    sfr_wr(3'd3, 8'h81);
    sfr_wr(3'd3, 8'h42);
    sfr_wr(3'd0, 8'h01);
    rises = 0;
    found = sck;
    for (int i = 0; i < 500 && rises < 3; i++) begin
      @(negedge clk);
      if (sck === 1'b1 && found === 1'b0) rises++;
      found = sck;
    end
    chk("abort_reach_bit3", rises, 3);
    sfr_wr(3'd0, 8'h00);
    chk("abort_ss_n", ss_n, 8'hFF);
    chk("abort_sck", sck, 1'b0);
    sfr_rd(3'd5, 1'b0, d);
    chk("abort_sr", d, 8'h08);

    // Reset mid-frame (CPOL=1 so SCK must drop back to 0)
    sfr_wr(3'd0, 8'h03);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ss_n !== '1 && mosi === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk("midframe_mosi_high", found, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ss_n", ss_n, 8'hFF);
    chk("mid_rst_sck", sck, 1'b0);
    chk("mid_rst_mosi", mosi, 1'b0);
    chk("mid_rst_irq", irq, 1'b0);
    rst = 1'b0;
    sfr_rd(3'd5, 1'b0, d);
    chk("mid_rst_sr", d, 8'h0A);
    sfr_rd(3'd0, 1'b0, d);
    chk("mid_rst_cr", d, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_master_fifo.md
# spi_master_fifo

Parametrised SPI master: the next generation of the SFR-mapped SPI controller. It adds a configurable word width and slave-select count, TX/RX FIFOs with burst transfers, all four CPOL/CPHA modes, MSB/LSB-first shifting, and sticky overflow flags. It sits on the same 3-bit SFR bus as the existing SPI block and drives the pad-level SCK/MOSI/SS lines directly.

## Interface
- DW, 8: SPI word width and SFR data width; must be ≥ 8.
- NSS, 8: number of active-low slave selects; must be ≤ DW.
- DEPTH, 4: depth of each of TX FIFO and RX FIFO; must be a power of 2 and ≥ 2.
- clk  in  1  system clock; every flop is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sfrwe  in  1  write strobe.
- sfraddr_w  in  3  write address.
- sfrdata_i  in  DW  write data.
- sfrre  in  1  read strobe; needed only for RXDR pop side effects.
- sfraddr_r  in  3  read address.
- sfrdata_o  out  DW  read data; combinational from sfraddr_r.
- miso  in  1  serial input.
- sck  out  1  serial clock.
- mosi  out  1  serial output.
- ss_n  out  NSS  slave selects, active low.
- irq  out  1  interrupt, level.

## Operation
- Register map:
  - 0 CR: [0] EN, [1] CPOL, [2] CPHA, [3] LSBF, [4] RXIE, [5] TXIE.
  - 1 SSEL: [NSS-1:0] one-hot select mask.
  - 2 BR: 8-bit; SCK half-period = BR+1 clk cycles.
  - 3 TXDR: write pushes the TX FIFO.
  - 4 RXDR: an sfrre read pops the RX FIFO.
  - 5 SR: [0] BUSY, [1] TXE, [2] TXF, [3] RXE, [4] RXF, [5] TXOVF, [6] RXOVF. Writing 1 to bit 5 or bit 6 clears that bit.
  - Addresses 6–7 read 0 and ignore writes. Unused high bits read 0.
- FIFO rules:
  - A push to a full TX FIFO is dropped and sets TXOVF.
  - An RXDR read when RX is empty returns 0 and does not pop.
  - Read data is the FIFO head, valid in the same cycle as the pop.
  - Simultaneous push and pop on one FIFO both take effect. The count is unchanged and order is preserved.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE → SETUP when EN=1 and TXE=0.
  - The FSM pops the TX word into the shift register.
  - It latches CPOL, CPHA, LSBF and BR; changes to these during a transfer take effect at the next SETUP.
  - ss_n = ~SSEL, taken from the current SSEL.
- SETUP lasts one half-period, then goes to SHIFT.
  - CPHA=0: the first bit is on mosi from SETUP entry.
- SHIFT consists of 2·DW half-periods. sck toggles at the end of each half-period, starting from CPOL.
  - CPHA=0: sample miso on odd edges, shift mosi on even edges.
  - CPHA=1: shift mosi on odd edges, sample miso on even edges.
  - Bit order is MSB first, or LSB first when LSBF=1.
- At the last edge the received word is pushed to RX.
  - If RX is full, the word is dropped and RXOVF is set.
  - If TXE=0, the FSM pops the next word and re-enters SHIFT directly. SS stays asserted and there is no SETUP. This is a burst.
  - Otherwise the FSM goes to HOLD.
- HOLD lasts one half-period with sck=CPOL, then ss_n goes all-ones and the FSM returns to IDLE.
- Abort: EN written 0 in any non-IDLE state.
  - Next cycle the FSM is in IDLE, ss_n is all ones and sck=CPOL.
  - The partial word is discarded; FIFO contents are retained.
- BUSY = (state ≠ IDLE).
- irq = (RXIE & ~RXE) | (TXIE & TXE & ~BUSY).

## Timing
- Reset values:
  - Registers: CR=0, SSEL=0, BR=0; FIFOs empty; SR=0x0A (TXE=1, RXE=1).
  - Outputs: sck=0, mosi=0, ss_n all ones, irq=0, state IDLE.
- sfrdata_o reflects the register selected by sfraddr_r in the same cycle. SR is live.
- The TXDR write is registered at edge N. ss_n falls and state=SETUP at edge N+1.
- Single-word frame length: (BR+1)·(2·DW+2) clk cycles from ss_n fall to ss_n rise.
- A burst of k words lasts (BR+1)·(2·DW·k+2) cycles.
- The RX push is visible in SR at the edge after the last SCK edge.
- rst has priority over every other event mid-frame; all state returns to reset values at that edge.
- Divider wrap: the half-period counter runs from 0 to BR, then reloads 0. BR=0 gives sck = clk/2.

## Test plan
- Reset, then read all addresses. Required: SR=0x0A, ss_n all ones, sck=0, irq=0.
- Configuration CR=0x01, BR=1, SSEL=0x04, TXDR=0xA5, with miso looped to mosi. Required:
  - ss_n=0xFB for 36 cycles;
  - mosi shows 1,0,1,0,0,1,0,1 MSB-first;
  - RXDR=0xA5 afterwards; RXE=1 after the read.
- All four CPOL/CPHA modes with BR=0 against a model slave returning 0x3C; repeat with LSBF=1. Required:
  - sck idles at CPOL;
  - sampling is on the correct edge;
  - RX=0x3C in each case.
- Burst: push DEPTH words, then one more. Required:
  - TXOVF is set;
  - ss_n stays low across all DEPTH words with no gap;
  - RX fills. A further frame with RX full sets RXOVF; a W1C write to SR clears it.
- Abort and reset mid-frame:
  - Clear EN during bit 3. Required: ss_n is all ones next cycle, the FIFOs are intact, BUSY=0.
  - Assert rst mid-frame. Required: all outputs take their reset values on the next edge.
